mips_mc_controller: RTL and testbench
=====================================

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max wait cycles for mem_ready before abort (1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetb  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode Instruction[31:26] from instruction register.
REQ-005 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
REQ-007 PCSource, ALUOp, ALUSrcB  output  2 each  datapath mux/ALU selects.
REQ-008 state_dbg  output  4  current state encoding.
REQ-009 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-010 mem_timeout  output  1  one-cycle pulse on memory wait abort.

Function
REQ-011 States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; state_dbg shall equal the registered state.
REQ-012 Every control output not listed for a state shall be 0.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=1 only in the cycle mem_ready=1; then -> DECODE, else stay.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX (macro only), other -> FETCH with illegal_op=1 that cycle.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; -> MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD: MemRead=1, IorD=1; -> MEMWB on mem_ready, else stay.
REQ-017 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; -> FETCH on mem_ready, else stay.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALUWB.
REQ-020 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-023 Wait counter (8 bit) shall clear on entry to FETCH, MEMRD or MEMWR and increment each cycle in them with mem_ready=0.
REQ-024 If counter reaches TIMEOUT_CYCLES with mem_ready=0, next state = FETCH, mem_timeout=1 that cycle, and no IRWrite/PCWrite/RegWrite is issued for the aborted access.
REQ-025 mem_ready=1 in the timeout cycle shall take priority: normal completion, no mem_timeout.
REQ-026 mem_ready outside FETCH/MEMRD/MEMWR shall be ignored.
REQ-027 Latencies with zero wait: R-type/ADDI 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-028 op shall be sampled only in DECODE and MEMADR.

Reset
REQ-029 resetb=1 at a rising edge shall force state FETCH and counter 0, overriding all transitions including mid-wait.
REQ-030 While reset is sampled, outputs shall follow FETCH Moore values with IRWrite=PCWrite=0, illegal_op=mem_timeout=0.
REQ-031 First fetch shall begin the cycle after resetb deasserts.

Configuration
REQ-032 Macro MIPS_MC_ADDI_EN: defined -> op 001000 enters ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00) then ADDIWB (RegDst=0, MemtoReg=0, RegWrite=1) then FETCH.
REQ-033 Undefined -> op 001000 is illegal (REQ-014); encodings 10, 11 never reached.

Verification
REQ-034 Reset, op=000000, mem_ready=1 always -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7.
REQ-035 op=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemtoReg=1, RegWrite=1.
REQ-036 TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> mem_timeout pulse after 4 wait cycles, return to FETCH, IRWrite never 1.
REQ-037 op=111111 in DECODE -> illegal_op=1 one cycle, next state FETCH, no RegWrite/MemWrite.
REQ-038 resetb=1 during MEMWR wait -> FETCH next cycle, MemWrite=0 thereafter until re-reached.
REQ-039 op=001000 with and without MIPS_MC_ADDI_EN -> states 0,1,10,11,0 versus illegal_op pulse and return to 0.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM; `define MIPS_MC_ADDI_EN adds the ADDIEX/ADDIWB path for op 001000.
// Latency: Moore controls registered with state; fetch IRWrite/PCWrite, illegal_op, mem_timeout decode same-cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; after TIMEOUT_CYCLES idle cycles the access aborts to FETCH.
module mips_mc_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state_dbg,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctl_t;

  // Per-state Moore control word; anything not named for a state stays 0.
  function automatic ctl_t moore_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  ctl_t       ctl_q;
  ctl_t       ctl;
  logic       in_wait;
  logic       timeout_hit;
  logic       illegal_c;
  logic       fetch_done;

  always_comb begin
    in_wait     = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    timeout_hit = in_wait && !mem_ready && (wait_cnt == TIMEOUT_LIM);
  end

  // A FETCH timeout simply stays in FETCH; the counter clear restarts the fetch.
  always_comb begin
    state_nxt = state;
    illegal_c = 1'b0;
    case (state)
      FETCH:  if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_nxt = ADDIEX;
`endif
          default: begin
            illegal_c = 1'b1;
            state_nxt = FETCH;
          end
        endcase
      end
      MEMADR: state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)        state_nxt = MEMWB;
        else if (timeout_hit) state_nxt = FETCH;
      end
      MEMWB:  state_nxt = FETCH;
      MEMWR:  if (mem_ready || timeout_hit) state_nxt = FETCH;
      EXEC:   state_nxt = ALUWB;
      ALUWB:  state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
      JUMP:   state_nxt = FETCH;
`ifdef MIPS_MC_ADDI_EN
      ADDIEX: state_nxt = ADDIWB;
      ADDIWB: state_nxt = FETCH;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state    <= FETCH;
      wait_cnt <= '0;
      ctl_q    <= moore_ctl(FETCH);
    end else begin
      state <= state_nxt;
      ctl_q <= moore_ctl(state_nxt);
      // Counts only while parked in a wait state; any transition leaves it at 0.
      if (in_wait && !mem_ready && !timeout_hit)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
    end
  end

  // Reset presents FETCH controls immediately, even before the first reset edge.
  always_comb begin
    ctl         = resetb ? moore_ctl(FETCH) : ctl_q;
    fetch_done  = !resetb && (state == FETCH) && mem_ready;
    PCWrite     = ctl.pc_write | fetch_done;
    PCWriteCond = ctl.pc_write_cond;
    IorD        = ctl.iord;
    MemRead     = ctl.mem_read;
    MemWrite    = ctl.mem_write;
    IRWrite     = fetch_done;
    MemtoReg    = ctl.mem_to_reg;
    RegWrite    = ctl.reg_write;
    RegDst      = ctl.reg_dst;
    ALUSrcA     = ctl.alu_src_a;
    PCSource    = ctl.pc_source;
    ALUOp       = ctl.alu_op;
    ALUSrcB     = ctl.alu_src_b;
    illegal_op  = illegal_c && !resetb;
    mem_timeout = timeout_hit && !resetb;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench: instruction-level plan expanded into expected per-cycle states and controls.
module tb_mips_mc_controller;

  localparam int TO = 4;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
  localparam int S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_JUMP = 9, S_ADDIEX = 10, S_ADDIWB = 11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
`ifdef MIPS_MC_ADDI_EN
  localparam int ADDI = 1;
`else
  localparam int ADDI = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb, mem_ready;
  logic [5:0] op;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state_dbg;
  logic illegal_op, mem_timeout;

  mips_mc_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetb(resetb), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state_dbg(state_dbg), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  typedef struct {
    int         st;
    bit         rdy;
    logic [5:0] op;
    bit         rst;
    bit         irw;
    bit         ill;
    bit         tmo;
  } cyc_t;

  cyc_t plan[$];
  int   trace[$];
  int   n_chk = 0, n_pass = 0;
  int   n_irw = 0, n_rw = 0, n_ill = 0, n_tmo = 0, n_mw = 0, n_pwc = 0;

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic add(int st, bit rdy, logic [5:0] o, bit rst, bit irw, bit ill, bit tmo);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.op = o; c.rst = rst; c.irw = irw; c.ill = ill; c.tmo = tmo;
    plan.push_back(c);
  endtask

  task automatic fetch(int w, bit abort);
    for (int i = 0; i < w; i++) add(S_FETCH, 1'b0, rnd_op(), 0, 0, 0, 0);
    if (abort) add(S_FETCH, 1'b0, rnd_op(), 0, 0, 0, 1);
    else       add(S_FETCH, 1'b1, rnd_op(), 0, 1, 0, 0);
  endtask

  task automatic mem(int st, int w, bit abort);
    for (int i = 0; i < w; i++) add(st, 1'b0, rnd_op(), 0, 0, 0, 0);
    if (abort) add(st, 1'b0, rnd_op(), 0, 0, 0, 1);
    else       add(st, 1'b1, rnd_op(), 0, 0, 0, 0);
  endtask

  // One instruction: fetch with fw idle cycles, then the spec's state walk for its opcode.
  task automatic instr(logic [5:0] o, int fw, int mw, bit mabort);
    fetch(fw, 1'b0);
    case (o)
      OP_R: begin
        add(S_DECODE, rnd_bit(), o, 0, 0, 0, 0);
        add(S_EXEC, rnd_bit(), rnd_op(), 0, 0, 0, 0);
        add(S_ALUWB, rnd_bit(), rnd_op(), 0, 0, 0, 0);
      end
      OP_LW: begin
        add(S_DECODE, rnd_bit(), o, 0, 0, 0, 0);
        add(S_MEMADR, rnd_bit(), o, 0, 0, 0, 0);
        mem(S_MEMRD, mw, mabort);
        if (!mabort) add(S_MEMWB, rnd_bit(), rnd_op(), 0, 0, 0, 0);
      end
      OP_SW: begin
        add(S_DECODE, rnd_bit(), o, 0, 0, 0, 0);
        add(S_MEMADR, rnd_bit(), o, 0, 0, 0, 0);
        mem(S_MEMWR, mw, mabort);
      end
      OP_BEQ: begin
        add(S_DECODE, rnd_bit(), o, 0, 0, 0, 0);
        add(S_BRANCH, rnd_bit(), rnd_op(), 0, 0, 0, 0);
      end
      OP_J: begin
        add(S_DECODE, rnd_bit(), o, 0, 0, 0, 0);
        add(S_JUMP, rnd_bit(), rnd_op(), 0, 0, 0, 0);
      end
`ifdef MIPS_MC_ADDI_EN
      OP_ADDI: begin
        add(S_DECODE, rnd_bit(), o, 0, 0, 0, 0);
        add(S_ADDIEX, rnd_bit(), rnd_op(), 0, 0, 0, 0);
        add(S_ADDIWB, rnd_bit(), rnd_op(), 0, 0, 0, 0);
      end
`endif
      default: add(S_DECODE, rnd_bit(), o, 0, 0, 1, 0);
    endcase
  endtask

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,
  //  PCSource,ALUOp,ALUSrcB,illegal_op,mem_timeout}
  function automatic logic [17:0] exp_vec(cyc_t c);
    bit pcw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa;
    logic [1:0] pcs, aop, asb;
    int s;
    {pcw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    s = c.rst ? S_FETCH : c.st;
    case (s)
      S_FETCH:  begin mr = 1; asb = 2'b01; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; iord = 1; end
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin mw = 1; iord = 1; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_ALUWB:  begin rd = 1; rw = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: rw = 1;
      default: ;
    endcase
    irw = c.irw && !c.rst;
    pcw = pcw | irw;
    return {pcw, pwc, iord, mr, mw, irw, m2r, rw, rd, asa, pcs, aop, asb,
            c.ill && !c.rst, c.tmo && !c.rst};
  endfunction

  task automatic chk(string name, int idx, int got, int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, idx, got, want);
  endtask

  task automatic check_cycle(int idx, cyc_t c);
    logic [17:0] got;
    got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst,
           ALUSrcA, PCSource, ALUOp, ALUSrcB, illegal_op, mem_timeout};
    chk("state_dbg", idx, int'(state_dbg), c.st);
    chk("controls", idx, int'(got), int'(exp_vec(c)));
    trace.push_back(int'(state_dbg));
    n_irw += int'(IRWrite);
    n_rw  += int'(RegWrite);
    n_ill += int'(illegal_op);
    n_tmo += int'(mem_timeout);
    n_mw  += int'(MemWrite);
    n_pwc += int'(PCWriteCond);
  endtask

  initial begin
    int v;
    resetb = 1'b1; op = '0; mem_ready = 1'b0;

    add(S_FETCH, 1'b0, 6'd0, 1, 0, 0, 0);
    add(S_FETCH, 1'b1, 6'd0, 1, 0, 0, 0);     // ready during reset must not fetch
    instr(OP_R, 0, 0, 0);
    instr(OP_LW, 0, 3, 0);
    instr(OP_SW, 1, 0, 0);
    instr(OP_BEQ, 0, 0, 0);
    instr(OP_J, 2, 0, 0);
    instr(6'b111111, 0, 0, 0);
    instr(OP_ADDI, 0, 0, 0);
    fetch(TO, 1'b1);                           // fetch abort
    instr(OP_R, TO, 0, 0);                     // ready exactly at the limit wins
    instr(OP_LW, 0, TO, 1);                    // load abort, no MEMWB
    fetch(0, 1'b0);                            // store cut by reset mid-wait
    add(S_DECODE, rnd_bit(), OP_SW, 0, 0, 0, 0);
    add(S_MEMADR, rnd_bit(), OP_SW, 0, 0, 0, 0);
    add(S_MEMWR, 1'b0, rnd_op(), 0, 0, 0, 0);
    add(S_MEMWR, 1'b0, rnd_op(), 0, 0, 0, 0);
    add(S_MEMWR, 1'b0, rnd_op(), 1, 0, 0, 0);
    add(S_FETCH, 1'b1, rnd_op(), 1, 0, 0, 0);
    instr(OP_R, 0, 0, 0);
    instr(OP_SW, 0, TO, 1);                    // store abort
    instr(OP_BEQ, 0, 0, 0);

    @(posedge clk); #1;
    foreach (plan[i]) begin
      resetb    = plan[i].rst;
      mem_ready = plan[i].rdy;
      op        = plan[i].op;
      @(negedge clk);
      check_cycle(i, plan[i]);
      @(posedge clk); #1;
    end

    v = 0;
    for (int k = 2; k <= 6; k++) v = v * 16 + trace[k];
    chk("rtype_seq", 2, v, 'h01670);
    v = 0;
    for (int k = 9; k <= 13; k++) v = v * 16 + trace[k];
    chk("lw_wait_seq", 9, v, 'h33334);
    chk("irwrite_count", -1, n_irw, 13);
    chk("regwrite_count", -1, n_rw, 4 + ADDI);
    chk("illegal_count", -1, n_ill, 2 - ADDI);
    chk("timeout_count", -1, n_tmo, 3);
    chk("memwrite_count", -1, n_mw, 8);
    chk("pcwritecond_count", -1, n_pwc, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
